alu_share_arbiter: RTL

- Two-requester round-robin arbiter and sequencer that time-shares one combinational RISC-V ALU.
- Requester 0 is the execute path. Requester 1 is the branch/jump address path.
- Each accepted request drives the ALU for exactly one cycle. The ALU result and Z/N flags are registered into a per-requester response slot, which is held until consumed.
- Sits between the core's issue logic and the single ALU instance.

---
 rtl/alu_share_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Round-robin arbiter/sequencer time-sharing one combinational ALU
//             between the execute path (0) and the branch address path (1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_cntrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_cntrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic [CTRL_W-1:0] alu_cntrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_data,
    output logic              rsp0_z,
    output logic              rsp0_n,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_data,
    output logic              rsp1_z,
    output logic              rsp1_n,
    output logic              busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              r_owner;
    logic [CTRL_W-1:0] r_cntrl;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;

    logic [1:0]        r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_data [2];
    logic [1:0]        r_rsp_z;
    logic [1:0]        r_rsp_n;

    logic [1:0]        w_req_valid;
    logic [1:0]        w_rsp_ready;
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic              w_capture;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};
    // A full slot that is draining this cycle counts as free (bypass).
    assign w_elig      = w_req_valid & (~r_rsp_valid | w_rsp_ready);
    assign w_capture   = (r_state == S_EXEC);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    if (w_elig == 2'b11) begin
                        w_gnt = r_prio ? 2'b10 : 2'b01;
                    end else begin
                        w_gnt = w_elig;
                    end
                end
                if (w_gnt != 2'b00) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];
    assign busy       = w_capture;
    assign alu_cntrl  = w_capture ? r_cntrl : '0;
    assign alu_a      = w_capture ? r_a     : '0;
    assign alu_b      = w_capture ? r_b     : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_cntrl <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt != 2'b00) begin
                r_owner <= w_gnt[1];
                r_cntrl <= w_gnt[1] ? req1_cntrl : req0_cntrl;
                r_a     <= w_gnt[1] ? req1_a     : req0_a;
                r_b     <= w_gnt[1] ? req1_b     : req0_b;
            end
            if (w_capture) begin
                r_prio <= ~r_owner;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        localparam bit c_id = (i == 1);

        // Capture takes precedence over a same-edge drain of the slot.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rsp_valid[i] <= 1'b0;
                r_rsp_data[i]  <= '0;
                r_rsp_z[i]     <= 1'b0;
                r_rsp_n[i]     <= 1'b0;
            end else if (w_capture && (r_owner == c_id)) begin
                r_rsp_valid[i] <= 1'b1;
                r_rsp_data[i]  <= alu_out;
                r_rsp_z[i]     <= alu_z;
                r_rsp_n[i]     <= alu_n;
            end else if (r_rsp_valid[i] && w_rsp_ready[i]) begin
                r_rsp_valid[i] <= 1'b0;
            end
        end
    end

    assign rsp0_valid = r_rsp_valid[0];
    assign rsp0_data  = r_rsp_data[0];
    assign rsp0_z     = r_rsp_z[0];
    assign rsp0_n     = r_rsp_n[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp1_data  = r_rsp_data[1];
    assign rsp1_z     = r_rsp_z[1];
    assign rsp1_n     = r_rsp_n[1];

endmodule

`default_nettype wire
